imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader sitting directly upstream of instruction_fetch. Accepts a stream
//  of 32-bit MIPS words over a valid/ready handshake, writes them into instruction memory via
//  the init_mode/write_enable/init_address/init_instruction port, then releases the CPU.
//  Holds the PC in reset until the image is complete. Provides a running XOR checksum for bring-up.
// PARAMETERS
//  ADDR_W     12             width of init_address (word index into instruction memory)
//  DATA_W     32             instruction word width
//  MAX_WORDS  (1<<ADDR_W)    largest legal word_count
// PORTS
//  clk               in   1       single clock; all state on posedge clk
//  reset_n           in   1       one clock; reset is asynchronous and active-low
//  start             in   1       pulse: latch word_count, begin load (IDLE or RUN only)
//  abort             in   1       level: cancel an in-progress load
//  word_count        in   ADDR_W+1  number of words to load, sampled with start
//  in_valid          in   1       stream word present
//  in_data           in   DATA_W  stream word
//  in_ready          out  1       loader accepts in_data this cycle
//  init_mode         out  1       to instruction_fetch: memory in init mode
//  write_enable      out  1       to instruction_fetch: write strobe, one cycle per word
//  init_address      out  ADDR_W  to instruction_fetch: word index being written
//  init_instruction  out  DATA_W  to instruction_fetch: word being written
//  cpu_reset         out  1       active-high reset to instruction_fetch/PC
//  done              out  1       image loaded, CPU running
//  error             out  1       sticky: bad word_count or abort; cleared by next accepted start
//  checksum          out  DATA_W  XOR of all words accepted in current load
// BEHAVIOUR
//  - Reset (reset_n=0, async): state IDLE; cpu_reset=1; all other outputs 0; counters 0.
//  - States: IDLE -> LOAD -> DRAIN -> RELEASE -> RUN. All outputs registered except in_ready.
//  - IDLE: start with 1<=word_count<=MAX_WORDS -> LOAD, error<=0, checksum<=0, index<=0.
//    start with word_count==0 or >MAX_WORDS -> stay IDLE, error<=1.
//  - LOAD: init_mode=1; in_ready = (remaining!=0) (combinational from state/counter).
//    Handshake = in_valid & in_ready. Cycle after each handshake: write_enable=1,
//    init_address=index, init_instruction=in_data; index++, checksum ^= in_data.
//    No handshake -> write_enable=0 next cycle, address/data hold. in_valid may drop anytime.
//  - Handshake on last word -> DRAIN (in_ready=0); DRAIN carries the final write, then RELEASE.
//  - RELEASE: init_mode=0, write_enable=0, cpu_reset still 1 (one settle cycle) -> RUN.
//  - RUN: cpu_reset=0, done=1. start with legal word_count -> LOAD, cpu_reset=1 and done=0
//    next cycle (reload); illegal start in RUN -> error=1, CPU keeps running.
//  - Latency: start at cycle t0, continuous in_valid: accepts t1..tN, writes t2..tN+1,
//    RELEASE tN+2, RUN (cpu_reset=0, done=1) visible at tN+3.
//  - abort in LOAD or DRAIN -> IDLE next cycle, error=1, init_mode=0, write_enable=0,
//    cpu_reset=1; a write already registered is dropped. abort ignored in IDLE/RELEASE/RUN.
//  - start ignored in LOAD/DRAIN/RELEASE; abort wins over start in the same cycle.
//  - word_count==MAX_WORDS: index wraps to 0 only after the final write; never double-writes.
//  - reset_n asserted mid-load: immediate return to reset values; memory contents undefined.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE, LOAD, DRAIN, RELEASE, RUN), PC reset
//    vector 32'h00400000 constant, ADDR_W/DATA_W defaults shared with instruction_fetch.
//  - Single flat module; no sub-module (FSM + two counters + checksum register).
// TESTING
//  - Reset: reset_n=0 mid-cycle -> cpu_reset=1, init_mode=0, done=0, error=0 asynchronously.
//  - Load 4 words {24020005,24030007,00432020,0000000C}, valid held high: writes addr 0..3 on
//    t2..t5, done=1 at t7, checksum=XOR of the four words, cpu_reset falls at t7.
//  - Bursty source: in_valid toggles 1010..; write_enable pulses only after handshakes,
//    addresses contiguous 0..N-1, no duplicate or skipped writes.
//  - start with word_count=0 and word_count=MAX_WORDS+1 -> error=1, state IDLE, no writes.
//  - abort after 2 of 5 words -> IDLE next cycle, error=1, cpu_reset=1, no further writes;
//    subsequent legal start clears error and loads from address 0.
//  - start while in RUN (reload 1 word) -> cpu_reset=1, done=0 next cycle; done again at t4.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Holds the default memory geometry used by both the loader and
// instruction_fetch, the PC reset vector, and the loader state encoding.
package imem_loader_pkg;

   localparam int IMEM_ADDR_W = 12;
   localparam int IMEM_DATA_W = 32;

   localparam logic [31:0] PC_RESET_VECTOR = 32'h0040_0000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_RUN     = 3'd4
   } ldr_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot-time program loader placed upstream of instruction_fetch.
// Accepts a word stream over valid/ready, writes each word into instruction
// memory through the init port, then releases the CPU from reset.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start, word_count   begin a load of word_count words (IDLE or RUN only)
//   abort               cancel a load in progress (LOAD or DRAIN)
//   in_valid, in_data   incoming word stream; in_ready is the accept strobe
//   init_mode, write_enable, init_address, init_instruction
//                       instruction memory init port
//   cpu_reset           active-high reset to PC / instruction_fetch
//   done                image loaded, CPU running
//   error               sticky: illegal word_count or abort
//   checksum            XOR of all words accepted in the current load
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no image; CPU held in reset, waiting for start
// LOAD    | accepting words; each handshake becomes a write next cycle
// DRAIN   | last word accepted; this cycle carries the final write
// RELEASE | init_mode dropped, CPU still in reset for one settle cycle
// RUN     | CPU running; a legal start reloads from address 0
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int DATA_W    = IMEM_DATA_W,
   parameter int MAX_WORDS = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   word_count,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              init_mode,
   output logic              write_enable,
   output logic [ADDR_W-1:0] init_address,
   output logic [DATA_W-1:0] init_instruction,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

   ldr_state_e        state;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W-1:0] index;

   logic start_ok;
   logic start_window;
   logic handshake;

   assign start_ok     = (word_count != '0) && (word_count <= MAX_CNT);
   assign start_window = (state == ST_IDLE) || (state == ST_RUN);
   assign in_ready     = (state == ST_LOAD) && (remaining != '0);
   assign handshake    = in_valid & in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_IDLE;
         remaining        <= '0;
         index            <= '0;
         init_mode        <= 1'b0;
         write_enable     <= 1'b0;
         init_address     <= '0;
         init_instruction <= '0;
         cpu_reset        <= 1'b1;
         done             <= 1'b0;
         error            <= 1'b0;
         checksum         <= '0;
      end else begin
         // write strobe is a single-cycle pulse per accepted word
         write_enable <= 1'b0;

         if (start && start_window) begin
            if (start_ok) begin
               state     <= ST_LOAD;
               remaining <= word_count;
               index     <= '0;
               checksum  <= '0;
               error     <= 1'b0;
               init_mode <= 1'b1;
               cpu_reset <= 1'b1;
               done      <= 1'b0;
            end else begin
               // an illegal request leaves a running CPU untouched
               error <= 1'b1;
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_IDLE;
               end
               ST_LOAD: begin
                  if (abort) begin
                     state     <= ST_IDLE;
                     error     <= 1'b1;
                     init_mode <= 1'b0;
                     cpu_reset <= 1'b1;
                  end else if (handshake) begin
                     write_enable     <= 1'b1;
                     init_address     <= index;
                     init_instruction <= in_data;
                     // at MAX_WORDS this wraps to 0 only after the last write
                     index            <= index + 1'b1;
                     checksum         <= checksum ^ in_data;
                     remaining        <= remaining - 1'b1;
                     if (remaining == (ADDR_W+1)'(1)) begin
                        state <= ST_DRAIN;
                     end
                  end
               end
               ST_DRAIN: begin
                  if (abort) begin
                     state     <= ST_IDLE;
                     error     <= 1'b1;
                     init_mode <= 1'b0;
                     cpu_reset <= 1'b1;
                  end else begin
                     state     <= ST_RELEASE;
                     init_mode <= 1'b0;
                  end
               end
               ST_RELEASE: begin
                  state     <= ST_RUN;
                  cpu_reset <= 1'b0;
                  done      <= 1'b1;
               end
               ST_RUN: begin
                  state <= ST_RUN;
               end
               default: begin
                  state     <= ST_IDLE;
                  init_mode <= 1'b0;
                  cpu_reset <= 1'b1;
                  done      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
